// File: rtl/line_sensor_decode.sv
// Line-sensor front end: synchronises and debounces the five IR sensors, decodes the
// filtered pattern into dirControl and runs the junction-hold and lost-line search FSM.
module line_sensor_decode #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int JNC_HOLD        = 25_000_000,
    parameter int LOST_TIMEOUT    = 100_000_000,
    parameter int CNT_W           = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sensor,
    output logic [3:0] dirControl,
    output logic       junction,
    output logic       lineLost
);
    typedef enum logic [1:0] {S_TRACK, S_JUNCTION, S_SEARCH, S_LOST} state_t;
    typedef enum logic [1:0] {SIDE_NONE, SIDE_LEFT, SIDE_RIGHT} side_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(JNC_HOLD);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_TIMEOUT - 1);
    localparam logic [4:0]       PAT_RESET = 5'b00100;
    localparam logic [3:0]       DIR_STOP  = 4'b1100;

    logic [4:0]       r_sync1, r_sync2, r_cand, r_filtered;
    logic [CNT_W-1:0] r_deb_cnt, w_deb_next;
    state_t           r_state;
    side_t            r_side, w_cmd_side;
    logic [CNT_W-1:0] r_hold_cnt, r_search_cnt, w_search_next;
    logic [3:0]       r_dir, w_cmd, w_search_dir;
    logic             w_cmd_valid, w_is_jnc, w_is_empty;
    logic             r_junction, r_lost;

    // Counter restarts whenever the synchronised value moves away from the candidate.
    assign w_deb_next = (r_sync2 != r_cand)    ? '0 :
                        (r_deb_cnt == DEB_LAST) ? r_deb_cnt : r_deb_cnt + CNT_W'(1);

    assign w_search_next = (r_search_cnt == LOST_LAST) ? r_search_cnt
                                                        : r_search_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= PAT_RESET;
            r_sync2    <= PAT_RESET;
            r_cand     <= PAT_RESET;
            r_deb_cnt  <= '0;
            r_filtered <= PAT_RESET;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_sync1   <= sensor;
            r_sync2   <= r_sync1;
            r_cand    <= r_sync2;
            r_deb_cnt <= w_deb_next;
            if (w_deb_next == DEB_LAST)
                r_filtered <= r_sync2;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_cmd       = 4'b0000;
        w_cmd_valid = 1'b1;
        w_is_jnc    = 1'b0;
        w_is_empty  = 1'b0;
        case (r_filtered)
            5'b00100, 5'b01110: w_cmd = 4'b0000;
            5'b01100:           w_cmd = 4'b0101;
            5'b00110:           w_cmd = 4'b1001;
            5'b01000, 5'b11000: w_cmd = 4'b0110;
            5'b00010, 5'b00011: w_cmd = 4'b1010;
            5'b10000:           w_cmd = 4'b0111;
            5'b00001:           w_cmd = 4'b1011;
            5'b11111, 5'b11110, 5'b01111, 5'b11100, 5'b00111: begin
                w_cmd_valid = 1'b0;
                w_is_jnc    = 1'b1;
            end
            5'b00000: begin
                w_cmd_valid = 1'b0;
                w_is_empty  = 1'b1;
            end
            default: w_cmd_valid = 1'b0;
        endcase

        case (w_cmd[3:2])
            2'b01:   w_cmd_side = SIDE_LEFT;
            2'b10:   w_cmd_side = SIDE_RIGHT;
            default: w_cmd_side = SIDE_NONE;
        endcase

        case (r_side)
            SIDE_LEFT:  w_search_dir = 4'b0111;
            SIDE_RIGHT: w_search_dir = 4'b1011;
            default:    w_search_dir = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_TRACK;
            r_side       <= SIDE_NONE;
            r_hold_cnt   <= '0;
            r_search_cnt <= '0;
            r_dir        <= 4'b0000;
            r_junction   <= 1'b0;
            r_lost       <= 1'b0;
        end else begin
            r_junction <= 1'b0;
            case (r_state)
                S_TRACK: begin
                    if (w_is_jnc) begin
                        r_state    <= S_JUNCTION;
                        r_dir      <= DIR_STOP;
                        r_junction <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (w_is_empty) begin
                        r_state      <= S_SEARCH;
                        r_dir        <= w_search_dir;
                        r_search_cnt <= '0;
                    end else if (w_cmd_valid) begin
                        r_dir  <= w_cmd;
                        r_side <= w_cmd_side;
                    end
                end
                S_JUNCTION: begin
                    // The drive block is mid-turn until the hold expires; ignore the sensors.
                    if (r_hold_cnt != HOLD_END) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end else if (!w_is_jnc && !w_is_empty) begin
                        r_state <= S_TRACK;
                        if (w_cmd_valid) begin
                            r_dir  <= w_cmd;
                            r_side <= w_cmd_side;
                        end
                    end
                end
                S_SEARCH: begin
                    if (w_is_jnc) begin
                        r_state      <= S_JUNCTION;
                        r_dir        <= DIR_STOP;
                        r_junction   <= 1'b1;
                        r_hold_cnt   <= '0;
                        r_search_cnt <= '0;
                    end else if (!w_is_empty) begin
                        r_state      <= S_TRACK;
                        r_search_cnt <= '0;
                        if (w_cmd_valid) begin
                            r_dir  <= w_cmd;
                            r_side <= w_cmd_side;
                        end
                    end else begin
                        r_search_cnt <= w_search_next;
                        if (w_search_next == LOST_LAST) begin
                            r_state <= S_LOST;
                            r_dir   <= DIR_STOP;
                            r_lost  <= 1'b1;
                        end
                    end
                end
                S_LOST: begin
                    if (w_is_jnc) begin
                        r_state    <= S_JUNCTION;
                        r_dir      <= DIR_STOP;
                        r_junction <= 1'b1;
                        r_hold_cnt <= '0;
                        r_lost     <= 1'b0;
                    end else if (!w_is_empty) begin
                        r_state      <= S_TRACK;
                        r_lost       <= 1'b0;
                        r_search_cnt <= '0;
                        if (w_cmd_valid) begin
                            r_dir  <= w_cmd;
                            r_side <= w_cmd_side;
                        end
                    end
                end
                default: r_state <= S_TRACK;
            endcase
        end
    end

    assign dirControl = r_dir;
    assign junction   = r_junction;
    assign lineLost   = r_lost;
endmodule

// File: tb/tb_line_sensor_decode.sv
// Scenario bench for line_sensor_decode with short sim parameters; expected
// {dirControl, junction, lineLost} per cycle are queued when stimulus is driven.
module tb_line_sensor_decode;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int LOST = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sensor;
    logic [3:0] dirControl;
    logic       junction;
    logic       lineLost;

    logic [5:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    line_sensor_decode #(
        .DEBOUNCE_CYCLES(DEB),
        .JNC_HOLD       (HOLD),
        .LOST_TIMEOUT   (LOST),
        .CNT_W          (27)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor    (sensor),
        .dirControl(dirControl),
        .junction  (junction),
        .lineLost  (lineLost)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] d, input logic j, input logic l, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({d, j, l});
    endtask

    task automatic test_reset();
        logic [5:0] got, exp;
        rst    = 1'b0;
        sensor = 5'b00100;
        push(4'b0000, 1'b0, 1'b0, 1);
        #12;
        got = {dirControl, junction, lineLost};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_held got=%b expected=%b (dir,jnc,lost)", got, exp);
        end
        @(negedge clk) rst = 1'b1;
        push(4'b0000, 1'b0, 1'b0, 8);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_idle k=%0d got=%b expected=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [5:0] got, exp;
        sensor = 5'b01100;
        push(4'b0000, 1'b0, 1'b0, 14);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL glitch k=%0d got=%b expected=%b", k, got, exp);
            end
            if (k == 3) sensor = 5'b00100;
        end
    endtask

    task automatic test_latency();
        logic [5:0] got, exp;
        sensor = 5'b01100;
        push(4'b0000, 1'b0, 1'b0, 6);
        push(4'b0101, 1'b0, 1'b0, 4);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL latency k=%0d got=%b expected=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_junction();
        logic [5:0] got, exp;
        sensor = 5'b11111;
        push(4'b0101, 1'b0, 1'b0, 6);
        push(4'b1100, 1'b1, 1'b0, 1);
        push(4'b1100, 1'b0, 1'b0, 10);
        push(4'b0000, 1'b0, 1'b0, 5);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL junction k=%0d got=%b expected=%b", k, got, exp);
            end
            if (k == 11) sensor = 5'b00100;
        end
    endtask

    task automatic test_search_lost();
        logic [5:0] got, exp;
        sensor = 5'b01000;
        push(4'b0000, 1'b0, 1'b0, 6);
        push(4'b0110, 1'b0, 1'b0, 8);
        push(4'b0111, 1'b0, 1'b0, LOST - 1);
        push(4'b1100, 1'b0, 1'b1, 5);
        for (int k = 1; k <= 38; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL search_lost k=%0d got=%b expected=%b", k, got, exp);
            end
            if (k == 8) sensor = 5'b00000;
        end
    endtask

    task automatic test_recover();
        logic [5:0] got, exp;
        sensor = 5'b00110;
        push(4'b1100, 1'b0, 1'b1, 6);
        push(4'b1001, 1'b0, 1'b0, 4);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL recover k=%0d got=%b expected=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_junction();
        logic [5:0] got, exp;
        sensor = 5'b11111;
        push(4'b1001, 1'b0, 1'b0, 6);
        push(4'b1100, 1'b1, 1'b0, 1);
        push(4'b1100, 1'b0, 1'b0, 5);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_jnc_pre k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        rst = 1'b0;
        push(4'b0000, 1'b0, 1'b0, 2);
        #1;
        got = {dirControl, junction, lineLost};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_jnc_async got=%b expected=%b", got, exp);
        end
        sensor = 5'b00100;
        repeat (2) @(posedge clk);
        #1;
        got = {dirControl, junction, lineLost};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_jnc_held got=%b expected=%b", got, exp);
        end
        @(negedge clk) rst = 1'b1;
        push(4'b0000, 1'b0, 1'b0, 4);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_jnc_release k=%0d got=%b expected=%b", k, got, exp);
            end
        end
        // A steering command only takes effect from TRACK, so this shows where reset left the FSM.
        sensor = 5'b01100;
        push(4'b0000, 1'b0, 1'b0, 6);
        push(4'b0101, 1'b0, 1'b0, 3);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            got = {dirControl, junction, lineLost};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_jnc_track k=%0d got=%b expected=%b", k, got, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_latency();
        test_junction();
        test_search_lost();
        test_recover();
        test_reset_mid_junction();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
